// File: rtl/spi_slave_stream.sv
// SPI slave exchanging a continuous stream of WIDTH-bit words per chip-select frame.
// Bus pins are oversampled in the system_clk domain; all four SPI modes and both bit orders.
module spi_slave_stream #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             system_clk,
    input  logic             system_nrst,
    input  logic             pin_ncs,
    input  logic             pin_clk,
    input  logic             pin_mosi,
    output logic             pin_miso,
    output logic             pin_miso_en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             cs_start,
    output logic             cs_stop,
    output logic             frame_error
);
    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ncs_sync_q, ncs_sync_d;
    logic [2:0]        clk_sync_q, clk_sync_d;
    logic [2:0]        mosi_sync_q, mosi_sync_d;
    logic [1:0]        flush_q, flush_d;
    logic              armed_q, armed_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              wrapped_q, wrapped_d;
    logic [WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]  rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              cs_start_q, cs_start_d;
    logic              cs_stop_q, cs_stop_d;
    logic              frame_error_q, frame_error_d;

    logic              ncs_fall, ncs_rise, clk_rise, clk_fall;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              active, frame_start, frame_stop, do_sample, do_shift, load;
    logic [CW-1:0]     cnt_after;

    assign ncs_fall    = ncs_sync_q[2] & ~ncs_sync_q[1];
    assign ncs_rise    = ~ncs_sync_q[2] & ncs_sync_q[1];
    assign clk_rise    = ~clk_sync_q[2] & clk_sync_q[1];
    assign clk_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign lead_edge   = CPOL ? clk_fall : clk_rise;
    assign trail_edge  = CPOL ? clk_rise : clk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign active      = (state_q == ACTIVE);
    assign frame_start = (state_q == IDLE) & armed_q & ncs_fall;
    assign frame_stop  = active & ncs_rise;
    assign do_sample   = active & sample_edge;
    assign do_shift    = active & shift_edge;
    // CPHA=0 preloads at frame start, so a zero count on a shift edge only reloads after a wrap
    assign load        = (frame_start & ~CPHA) |
                         (do_shift & (bit_cnt_q == '0) & (CPHA | wrapped_q));

    always_ff @(posedge system_clk or negedge system_nrst) begin
        if (!system_nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = ACTIVE;
            ACTIVE:  if (ncs_rise)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ncs_sync_d    = {ncs_sync_q[1:0], pin_ncs};
        clk_sync_d    = {clk_sync_q[1:0], pin_clk};
        mosi_sync_d   = {mosi_sync_q[1:0], pin_mosi};
        flush_d       = {flush_q[0], 1'b1};
        // arm only once the ncs chain holds a genuinely sampled high level
        armed_d       = armed_q | (flush_q[1] & ncs_sync_q[1]);
        bit_cnt_d     = bit_cnt_q;
        wrapped_d     = wrapped_q;
        tx_sr_d       = tx_sr_q;
        rx_sr_d       = rx_sr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        cs_start_d    = frame_start;
        cs_stop_d     = 1'b0;
        frame_error_d = 1'b0;
        tx_ready      = 1'b0;
        tx_underrun   = 1'b0;
        cnt_after     = bit_cnt_q;

        if (frame_start) begin
            bit_cnt_d = '0;
            wrapped_d = 1'b0;
            rx_sr_d   = '0;
        end

        if (do_sample) begin
            rx_sr_d = LSB_FIRST ? {mosi_sync_q[2], rx_sr_q[WIDTH-1:1]}
                                : {rx_sr_q[WIDTH-2:0], mosi_sync_q[2]};
            if (bit_cnt_q == LAST) begin
                cnt_after  = '0;
                rx_data_d  = rx_sr_d;
                rx_valid_d = 1'b1;
                wrapped_d  = 1'b1;
            end else begin
                cnt_after  = bit_cnt_q + 1'b1;
            end
            bit_cnt_d = cnt_after;
        end

        if (load) begin
            tx_ready  = 1'b1;
            wrapped_d = 1'b0;
            if (tx_valid) begin
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d     = '0;
                tx_underrun = 1'b1;
            end
        end else if (do_shift && (bit_cnt_q != '0)) begin
            tx_sr_d = LSB_FIRST ? {1'b0, tx_sr_q[WIDTH-1:1]} : {tx_sr_q[WIDTH-2:0], 1'b0};
        end

        // a sample on the stop cycle counts first, so a just-finished word is no error
        if (frame_stop) begin
            cs_stop_d     = 1'b1;
            frame_error_d = (cnt_after != '0);
        end
    end

    always_ff @(posedge system_clk or negedge system_nrst) begin
        if (!system_nrst) begin
            ncs_sync_q    <= '1;
            clk_sync_q    <= {3{CPOL}};
            mosi_sync_q   <= '0;
            flush_q       <= '0;
            armed_q       <= 1'b0;
            bit_cnt_q     <= '0;
            wrapped_q     <= 1'b0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            cs_start_q    <= 1'b0;
            cs_stop_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            ncs_sync_q    <= ncs_sync_d;
            clk_sync_q    <= clk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            flush_q       <= flush_d;
            armed_q       <= armed_d;
            bit_cnt_q     <= bit_cnt_d;
            wrapped_q     <= wrapped_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            cs_start_q    <= cs_start_d;
            cs_stop_q     <= cs_stop_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign pin_miso    = LSB_FIRST ? tx_sr_q[0] : tx_sr_q[WIDTH-1];
    assign pin_miso_en = active & ~pin_ncs;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign cs_start    = cs_start_q;
    assign cs_stop     = cs_stop_q;
    assign frame_error = frame_error_q;

endmodule
